ysyx_22040237_ifu: RTL and testbench

Instruction fetch unit; the producer side of the decode interface. It owns the architectural PC and issues word fetches to instruction memory over a valid/ready request/response channel. It presents {pc, inst} to the decode stage with a valid/ready handshake. It accepts PC redirects (jal/jalr targets) from decode/execute and discards fetches made stale by a redirect.

---
 rtl/ysyx_22040237_ifu_pkg.sv | 23 ++
 rtl/ysyx_22040237_ifu.sv | 179 +++++++++++++++++
 tb/tb_ysyx_22040237_ifu.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040237_ifu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_ifu_pkg
//   Shared definitions for the instruction fetch unit. The decode stage and the
//   fetch testbench also use them.
//   - ifu_state_e  : fetch FSM encoding (BOOT/REQ/WAIT/HOLD, 2 bits)
//   - IFU_RESET_PC : default architectural PC after reset
//   - IFU_ZERO_INST: instruction word presented alongside an access fault
//   - IFU_PC_INC   : sequential PC step (one 32-bit instruction word)
// ---------------------------------------------------------------------------
package ysyx_22040237_ifu_pkg;

  typedef enum logic [1:0] {
    IFU_BOOT = 2'd0,  // one settling cycle after reset release
    IFU_REQ  = 2'd1,  // request to instruction memory is being offered
    IFU_WAIT = 2'd2,  // request accepted, response outstanding
    IFU_HOLD = 2'd3   // instruction buffered and presented to decode
  } ifu_state_e;

  localparam logic [63:0] IFU_RESET_PC  = 64'h0000_0000_8000_0000;
  localparam logic [31:0] IFU_ZERO_INST = 32'h0000_0000;
  localparam int unsigned IFU_PC_INC    = 4;

endpackage

// File: rtl/ysyx_22040237_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_ifu
//   Instruction fetch unit. Owns the architectural PC, fetches one word at a
//   time from instruction memory and hands {pc, inst} to decode. Redirects
//   from decode/execute replace the PC; any fetch already in flight for the
//   old PC is marked stale with a single kill bit and its response is dropped.
//
// Handshake rule (both request and output channels): a transfer happens in
//   the cycle where valid and ready are both 1 at the rising clock edge. Once
//   valid is raised, the payload stays stable until that transfer. The one
//   exception is the output channel on a redirect: the buffered instruction
//   is withdrawn because it is on the wrong path.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   imem_req_valid     fetch request valid (register driven)
//   imem_req_ready     memory accepts the request
//   imem_req_addr      word-aligned fetch address (register driven)
//   imem_resp_valid    response strobe; memory never stalls it
//   imem_resp_data     fetched instruction
//   imem_resp_err      access fault for this response
//   out_valid          {out_pc, out_inst, out_fault} valid to decode
//   out_ready          decode consumes the instruction
//   out_pc/out_inst    presented PC and instruction (register driven)
//   out_fault          presented instruction faulted; out_inst is zero
//   redirect_valid     single-cycle redirect strobe
//   redirect_pc        redirect target (low two bits ignored)
//   dbg_state_o        current FSM state for observation
// ---------------------------------------------------------------------------
module ysyx_22040237_ifu
  import ysyx_22040237_ifu_pkg::*;
#(
  parameter int unsigned     PC_W     = 64,
  parameter int unsigned     INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              imem_resp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_fault,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output ifu_state_e        dbg_state_o
);

  ifu_state_e        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   req_addr_q, req_addr_d;
  logic              kill_q, kill_d;
  logic [PC_W-1:0]   out_pc_q, out_pc_d;
  logic [INST_W-1:0] out_inst_q, out_inst_d;
  logic              out_fault_q, out_fault_d;

  logic [PC_W-1:0]   redirect_tgt;
  logic              resp_take;

  // Targets are forced onto a word boundary.
  assign redirect_tgt = {redirect_pc[PC_W-1:2], 2'b00};

  // A response is only meaningful while a request is outstanding; responses
  // seen in any other state (e.g. a leftover from before a reset) are ignored.
  assign resp_take = (state_q == IFU_WAIT) && imem_resp_valid;

  // -------------------------------------------------------------------------
  // State register and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IFU_BOOT;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      kill_q      <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      out_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      kill_q      <= kill_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_fault_q <= out_fault_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IFU_BOOT: state_d = IFU_REQ;
      IFU_REQ: begin
        if (imem_req_ready) state_d = IFU_WAIT;
      end
      IFU_WAIT: begin
        // A stale response (killed earlier, or made stale by a redirect in
        // this very cycle) is dropped and the fetch restarts at the new pc.
        if (imem_resp_valid) begin
          state_d = (kill_q || redirect_valid) ? IFU_REQ : IFU_HOLD;
        end
      end
      IFU_HOLD: begin
        // Consumption and redirect both leave HOLD; a redirect without
        // consumption discards the wrong-path instruction.
        if (out_ready || redirect_valid) state_d = IFU_REQ;
      end
      default: state_d = IFU_BOOT;
    endcase
  end

  // -------------------------------------------------------------------------
  // PC, kill bit, request address and output buffer
  // -------------------------------------------------------------------------
  always_comb begin
    pc_d        = pc_q;
    kill_d      = kill_q;
    req_addr_d  = req_addr_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_fault_d = out_fault_q;

    // The last redirect always wins. When decode consumes the jump in the
    // same cycle the redirect still takes priority over the sequential step.
    if (redirect_valid) begin
      pc_d = redirect_tgt;
    end else if ((state_q == IFU_HOLD) && out_ready) begin
      pc_d = pc_q + PC_W'(IFU_PC_INC);
    end

    // Kill marks a request for the old pc that is either still being offered
    // (it must complete with a stable address) or already outstanding. Any
    // response clears it, because that response is the stale one.
    if (resp_take) begin
      kill_d = 1'b0;
    end else if (redirect_valid &&
                 ((state_q == IFU_REQ) || (state_q == IFU_WAIT))) begin
      kill_d = 1'b1;
    end

    // A good response is captured; pc_q still equals the fetched address
    // because any redirect since the request would have set kill.
    if (resp_take && !kill_q && !redirect_valid) begin
      out_pc_d    = pc_q;
      out_fault_d = imem_resp_err;
      out_inst_d  = imem_resp_err ? INST_W'(IFU_ZERO_INST) : imem_resp_data;
    end

    // The request address is loaded only on entry to REQ, so it cannot move
    // while a request is being offered, even if pc changes underneath it.
    if ((state_d == IFU_REQ) && (state_q != IFU_REQ)) begin
      req_addr_d = pc_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registers only
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req_valid = (state_q == IFU_REQ);
    imem_req_addr  = req_addr_q;
    out_valid      = (state_q == IFU_HOLD);
    out_pc         = out_pc_q;
    out_inst       = out_inst_q;
    out_fault      = out_fault_q;
    dbg_state_o    = state_q;
  end

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
`timescale 1ns/1ps
module tb_ysyx_22040237_ifu;
  import ysyx_22040237_ifu_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid, imem_resp_err;
  logic [31:0] imem_resp_data;
  logic        out_valid, out_ready, out_fault;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  ifu_state_e  dbg_state;

  ysyx_22040237_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_fault       (out_fault),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dbg_state_o     (dbg_state)
  );

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Program image seen by the fetch unit.
  function automatic logic [31:0] inst_of(input logic [63:0] a);
    if (a == RST_PC) return 32'h0000_0413;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  function automatic logic err_of(input logic [63:0] a);
    return a[5:2] == 4'd3;
  endfunction

  // -------------------------------------------------------------------------
  // Reference model and scoreboard state
  //   exp_pc : pc the next consumed instruction must carry. Consumption steps
  //            it by 4; any redirect replaces it with the aligned target.
  //   exp_q  : expected request addresses for the directed section.
  // -------------------------------------------------------------------------
  logic [63:0] exp_pc;
  logic [63:0] exp_q[$];

  // Memory model: one outstanding request, response after mem_cnt cycles.
  logic        mem_pend;
  logic [63:0] mem_addr;
  int          mem_cnt;

  // Stimulus knobs applied by the driver each cycle.
  logic        k_req_ready, k_out_ready, k_redir;
  logic [63:0] k_redir_pc;
  int          k_delay;

  // Per-cycle observations.
  logic        f_req, f_out;
  logic [63:0] fire_pc;
  logic [31:0] fire_inst;
  logic        p_req_wait, p_out_wait, p_redir, p_out_fault;
  logic [63:0] p_addr, p_out_pc;
  logic [31:0] p_out_inst;
  int          n_req, n_out;

  task automatic reset_model();
    exp_pc     = RST_PC;
    mem_pend   = 1'b0;
    mem_cnt    = 0;
    p_req_wait = 1'b0;
    p_out_wait = 1'b0;
    p_redir    = 1'b0;
    f_req      = 1'b0;
    f_out      = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Driver: one clock cycle. Inputs change on the falling edge; outputs are
  // sampled 1ns later, which is what the next rising edge commits.
  // -------------------------------------------------------------------------
  task automatic cycle();
    @(negedge clk);
    imem_req_ready = k_req_ready;
    out_ready      = k_out_ready;
    redirect_valid = k_redir;
    redirect_pc    = k_redir_pc;
    if (mem_pend && mem_cnt == 1) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = inst_of(mem_addr);
      imem_resp_err   = err_of(mem_addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      imem_resp_err   = 1'($urandom_range(0, 1));
    end
    #1;

    if (p_req_wait) begin
      check_eq("req_hold_valid", imem_req_valid, 1);
      check_eq("req_hold_addr", imem_req_addr, p_addr);
    end
    if (p_out_wait && !p_redir) begin
      check_eq("out_hold_valid", out_valid, 1);
      check_eq("out_hold_pc", out_pc, p_out_pc);
      check_eq("out_hold_inst", out_inst, p_out_inst);
      check_eq("out_hold_fault", out_fault, p_out_fault);
    end
    if (p_out_wait && p_redir) check_eq("out_drop", out_valid, 0);

    f_req = imem_req_valid && imem_req_ready;
    f_out = out_valid && out_ready;
    if (f_req) begin
      check_eq("req_align", imem_req_addr[1:0], 0);
      check_eq("one_outstanding", mem_pend, 0);
      if (exp_q.size() != 0) check_eq("req_addr", imem_req_addr, exp_q.pop_front());
    end
    if (f_out) begin
      check_eq("out_pc", out_pc, exp_pc);
      check_eq("out_inst", out_inst, err_of(exp_pc) ? 64'h0 : 64'(inst_of(exp_pc)));
      check_eq("out_fault", out_fault, err_of(exp_pc));
      fire_pc   = out_pc;
      fire_inst = out_inst;
      n_out++;
      exp_pc = exp_pc + 64'd4;
    end
    if (redirect_valid) exp_pc = redirect_pc & ~64'h3;

    if (mem_pend) begin
      if (mem_cnt == 1) mem_pend = 1'b0;
      else mem_cnt--;
    end
    if (f_req) begin
      mem_pend = 1'b1;
      mem_addr = imem_req_addr;
      mem_cnt  = (k_delay != 0) ? k_delay : $urandom_range(1, 3);
      n_req++;
    end

    p_req_wait  = imem_req_valid && !imem_req_ready;
    p_addr      = imem_req_addr;
    p_out_wait  = out_valid && !out_ready;
    p_out_pc    = out_pc;
    p_out_inst  = out_inst;
    p_out_fault = out_fault;
    p_redir     = redirect_valid;
    k_redir     = 1'b0;
  endtask

  task automatic run_until_req(input int max, input string tag);
    int i = 0;
    do begin cycle(); i++; end while (!f_req && i < max);
    if (!f_req) check_eq({tag, "_timeout"}, f_req, 1);
  endtask

  task automatic run_until_outv(input int max, input string tag);
    int i = 0;
    do begin cycle(); i++; end while (!out_valid && i < max);
    if (!out_valid) check_eq({tag, "_timeout"}, out_valid, 1);
  endtask

  task automatic run_until_out_fire(input int max, input string tag);
    int i = 0;
    do begin cycle(); i++; end while (!f_out && i < max);
    if (!f_out) check_eq({tag, "_timeout"}, f_out, 1);
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int lat;
    int req0;
    int n0;
    imem_req_ready = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; imem_resp_err = 1'b0;
    k_req_ready = 1'b0; k_out_ready = 1'b0; k_redir = 1'b0; k_redir_pc = '0; k_delay = 1;
    n_req = 0; n_out = 0;
    reset_model();

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req_valid", imem_req_valid, 0);
    check_eq("rst_req_addr", imem_req_addr, RST_PC);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_pc", out_pc, 0);
    check_eq("rst_out_inst", out_inst, 0);
    check_eq("rst_out_fault", out_fault, 0);
    check_eq("rst_state", dbg_state, IFU_BOOT);

    exp_q = {RST_PC, RST_PC + 64'd4, 64'h8000_0008, 64'h8000_0200, 64'h8000_0204,
             64'h8000_000C, 64'h8000_0010, 64'h8000_0100, 64'h8000_0104, RST_PC};

    // Test 1: first fetch after reset, 1-cycle response.
    @(negedge clk);
    rst = 1'b1;
    #1 check_eq("boot_no_req", imem_req_valid, 0);
    k_req_ready = 1'b1; k_out_ready = 1'b0; k_delay = 1;
    cycle();
    check_eq("boot_one_cycle", f_req, 1);
    lat = 0;
    do begin cycle(); lat++; end while (!out_valid && lat < 10);
    check_eq("t1_latency", lat, 2);
    check_eq("t1_out_pc", out_pc, RST_PC);
    check_eq("t1_out_inst", out_inst, 32'h0000_0413);
    k_out_ready = 1'b1;
    cycle();
    check_eq("t1_consumed", f_out, 1);

    // Test 2: request backpressure for 5 cycles.
    k_req_ready = 1'b0; k_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("t2_bp_valid", imem_req_valid, 1);
      check_eq("t2_bp_addr", imem_req_addr, RST_PC + 64'd4);
    end
    k_req_ready = 1'b1;
    req0 = n_req;
    cycle();
    check_eq("t2_accept", f_req, 1);
    k_req_ready = 1'b0;
    repeat (3) cycle();
    check_eq("t2_one_req", n_req - req0, 1);
    k_req_ready = 1'b1; k_out_ready = 1'b1;
    run_until_out_fire(10, "t2_out");

    // Test 4: redirect while the response for 8000_0008 is outstanding.
    k_delay = 3;
    run_until_req(10, "t4_req");
    k_redir = 1'b1; k_redir_pc = 64'h8000_0200;
    cycle();
    k_delay = 1;
    run_until_req(20, "t4_refetch");
    run_until_out_fire(10, "t4_out");
    check_eq("t4_out_pc", fire_pc, 64'h8000_0200);

    // Test 5: redirect in HOLD without consumption, then faulting fetch.
    k_out_ready = 1'b0;
    run_until_outv(10, "t5_hold");
    k_redir = 1'b1; k_redir_pc = 64'h8000_000C;
    cycle();
    run_until_outv(10, "t5_fault");
    check_eq("t5_pc", out_pc, 64'h8000_000C);
    check_eq("t5_fault", out_fault, 1);
    check_eq("t5_inst", out_inst, 0);
    k_out_ready = 1'b1;
    cycle();
    check_eq("t5_consumed", f_out, 1);
    k_out_ready = 1'b0;

    // Test 3: redirect in HOLD together with consumption.
    run_until_outv(10, "t3_hold");
    check_eq("t3_pc", out_pc, 64'h8000_0010);
    k_out_ready = 1'b1; k_redir = 1'b1; k_redir_pc = 64'h8000_0102;
    cycle();
    check_eq("t3_consumed", f_out, 1);
    run_until_out_fire(10, "t3_out");
    check_eq("t3_target", fire_pc, 64'h8000_0100);

    // Test 6: asynchronous reset mid-WAIT, stale response during BOOT.
    k_delay = 3; k_out_ready = 1'b0;
    run_until_req(10, "t6_req");
    cycle();
    #2 rst = 1'b0;
    #1;
    check_eq("t6_rst_req_valid", imem_req_valid, 0);
    check_eq("t6_rst_out_valid", out_valid, 0);
    check_eq("t6_rst_req_addr", imem_req_addr, RST_PC);
    check_eq("t6_rst_state", dbg_state, IFU_BOOT);
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF; imem_resp_err = 1'b0;
    #1 check_eq("t6_boot_no_req", imem_req_valid, 0);
    k_req_ready = 1'b1; k_delay = 1; k_out_ready = 1'b1;
    cycle();
    check_eq("t6_boot_one_cycle", f_req, 1);
    run_until_out_fire(10, "t6_out");
    check_eq("t6_out_inst", fire_inst, 32'h0000_0413);
    check_eq("dir_queue_drained", exp_q.size(), 0);

    // Randomized traffic against the reference model.
    k_delay = 0;
    n0 = n_out;
    for (int i = 0; i < 4000; i++) begin
      k_req_ready = ($urandom_range(0, 3) != 0);
      k_out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 11) == 0) begin
        k_redir = 1'b1;
        if ($urandom_range(0, 1) == 1) k_redir_pc = {$urandom, $urandom};
        else k_redir_pc = 64'h8000_0000 | 64'($urandom_range(0, 4095));
      end
      cycle();
    end
    check_eq("random_progress", (n_out - n0) > 200, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
